cmp_operand_supplier: RTL
=========================

// Module: cmp_operand_supplier
// PURPOSE
// - Supplies the two D-stage branch-comparator operands and the D-stage stall. Tracks in-flight writers in E/M/W.
// - Sits between the GRF read ports and the comparator inputs.
// - Forwards the newest ready value for each operand. Stalls D while any newer writer's value is not yet produced.
// - Inserts a bubble into its own E-stage tracker on stall.
// PARAMETERS
// - DATA_W   32  operand / write-data width
// - ADDR_W   5   register address width; register 0 is hard-wired zero
// - TNEW_W   2   width of the Tnew countdown field (max Tnew = 2^TNEW_W-1)
// PORTS
// - clk         in   1        rising-edge clock
// - reset       in   1        asynchronous, active-high; clears all tracker state
// - d_rs        in   ADDR_W   D-stage operand A register address
// - d_rt        in   ADDR_W   D-stage operand B register address
// - d_use       in   1        D instruction reads d_rs/d_rt in D (branch); 0 = no stall request
// - grf_rs      in   DATA_W   GRF read data for d_rs
// - grf_rt      in   DATA_W   GRF read data for d_rt
// - d_issue     in   1        D instruction advances to E this cycle (ignored while stall=1)
// - d_dst       in   ADDR_W   destination register of the issuing instruction (0 = no write)
// - d_tnew      in   TNEW_W   cycles after entering E until its result exists (ALU=1, load=2, link=0)
// - e_wdata     in   DATA_W   value the E-stage instruction will write (valid when E tnew==0)
// - m_wdata     in   DATA_W   value the M-stage instruction will write
// - w_wdata     in   DATA_W   value the W-stage instruction writes
// - cmp_a       out  DATA_W   forwarded operand A to comparator
// - cmp_b       out  DATA_W   forwarded operand B to comparator
// - a_sel       out  2        A source: 0 GRF, 1 E, 2 M, 3 W
// - b_sel       out  2        B source, same encoding
// - stall       out  1        freeze PC and F/D; E receives a bubble
// BEHAVIOUR
// - Tracker state: three entries E, M, W, each holding {valid, dst, tnew}.
// - Reset (async) -> all valid=0. Outputs then: stall=0, a_sel=b_sel=0, cmp_a=grf_rs, cmp_b=grf_rt.
// - Every posedge, the tracker always shifts: W<=M, M<=E.
//   - tnew of each moved entry becomes max(tnew-1, 0); it saturates at 0.
// - E loading on the same posedge:
//   - if d_issue & ~stall: E <= {1, d_dst, d_tnew}
//   - otherwise: E <= bubble (valid=0)
// - Entry match for operand reg r: valid & dst==r & r!=0.
// - Per operand, search order E, M, W; the first matching entry decides the result:
//   - tnew==0 -> forward that stage's wdata; sel = 1/2/3
//   - tnew>0  -> operand not ready; no further search
//   - no match, or r==0 -> GRF value; sel = 0
// - stall = d_use & (A not ready | B not ready).
//   - d_use=0 -> stall=0; cmp_a/cmp_b are still driven by the forwarding rule.
// - Outputs are combinational from tracker state and inputs; no added latency.
// - An operand whose value is not ready drives its GRF value and sel=0; it is don't-care while stall=1.
// - Stall ends after at most Tnew cycles, because the countdowns are monotonic.
// - Reset asserted mid-stall clears stall in the same cycle, with no clock edge required.
// - d_issue is ignored when stall=1; the gating is internal, so no external AND is needed.
// - Writes to register 0 are tracked but never matched and never stall.
// TESTING
// - Post-reset: grf_rs=5, grf_rt=5, d_use=1 -> stall=0, a_sel=0, cmp_a=cmp_b=5.
// - Issue load (dst=8, tnew=2); next cycle d_rs=8, d_use=1:
//   - stall=1 for 2 cycles, E bubbles
//   - 3rd cycle: entry in W with tnew=0, w_wdata=0x1234 -> a_sel=3, cmp_a=0x1234, stall=0.
// - Issue ALU (dst=9, tnew=1); next cycle d_rt=9 -> stall=1 for 1 cycle, then b_sel=2, cmp_b=m_wdata.
// - Issue link (dst=31, tnew=0); next cycle d_rs=31, e_wdata=0x3004 -> stall=0, a_sel=1, cmp_a=0x3004.
// - Priority: E and M both dst=4, tnew=0 -> a_sel=1. Dst=0 in E with tnew=2 and d_rs=0 -> stall=0, cmp_a=grf_rs.
// - Reset raised during a load-use stall -> stall=0 immediately; tracker empty after release.

Source files
------------

// File: rtl/cmp_operand_supplier.sv
// cmp_operand_supplier: D-stage branch-comparator operand forwarding and load-use stall
module cmp_operand_supplier #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic              d_use,
  input  logic [DATA_W-1:0] grf_rs,
  input  logic [DATA_W-1:0] grf_rt,
  input  logic              d_issue,
  input  logic [ADDR_W-1:0] d_dst,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [DATA_W-1:0] e_wdata,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] w_wdata,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  output logic [1:0]        a_sel,
  output logic [1:0]        b_sel,
  output logic              stall
);
  logic [2:0]             v;
  logic [2:0][ADDR_W-1:0] dst;
  logic [2:0][TNEW_W-1:0] tn;
  logic                   a_rdy, b_rdy;
  function automatic logic [TNEW_W-1:0] dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? t : t - TNEW_W'(1);
  endfunction
  // {ready, sel}: the youngest matching entry decides; a pending one blocks older ones
  function automatic logic [2:0] pick(input logic [ADDR_W-1:0] r);
    logic [2:0]        m;
    logic [TNEW_W-1:0] t;
    logic [1:0]        sel;
    logic              rdy;
    for (int i = 0; i < 3; i++) m[i] = v[i] && dst[i] == r && r != '0;
    sel = m[0] ? 2'd1 : m[1] ? 2'd2 : m[2] ? 2'd3 : 2'd0;
    t   = m[0] ? tn[0] : m[1] ? tn[1] : tn[2];
    rdy = ~|m || t == '0;
    return {rdy, rdy ? sel : 2'd0};
  endfunction
  function automatic logic [DATA_W-1:0] fwd(input logic [1:0] s, input logic [DATA_W-1:0] g);
    return s == 2'd1 ? e_wdata : s == 2'd2 ? m_wdata : s == 2'd3 ? w_wdata : g;
  endfunction
  assign {a_rdy, a_sel} = pick(d_rs);
  assign {b_rdy, b_sel} = pick(d_rt);
  assign cmp_a = fwd(a_sel, grf_rs);
  assign cmp_b = fwd(b_sel, grf_rt);
  assign stall = d_use & ~(a_rdy & b_rdy);
  // index 0 = E, 1 = M, 2 = W
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v   <= '0;
      dst <= '0;
      tn  <= '0;
    end else begin
      v   <= {v[1:0], d_issue & ~stall};
      dst <= {dst[1:0], d_dst};
      tn  <= {dec(tn[1]), dec(tn[0]), d_tnew};
    end
endmodule
